// File: rtl/match_step_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | match_step_seq                                                             |
// | Button-stepped colour-match sequencer: show/select/check per round, miss   |
// | counting with retry, optional miss-limit lockout and status pulses.        |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module match_step_seq #(
    parameter int ROUNDS     = 3,
    parameter int COLOR_W    = 3,
    parameter logic [COLOR_W*(2**COLOR_W)-1:0] PARTNER = 24'hA394E6,
    parameter int END_STEPS  = 3,
    parameter int RETRY_MODE = 0,
    parameter int MAX_MISS   = 0,
    parameter int STEP_W     = 4,
    parameter int MISS_W     = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      button,
    input  logic [ROUNDS*COLOR_W-1:0] secim,
    input  logic [ROUNDS*COLOR_W-1:0] es,
    output logic [STEP_W-1:0]         step,
    output logic [2:0]                round,
    output logic [MISS_W-1:0]         miss_cnt,
    output logic                      match_pulse,
    output logic                      miss_pulse,
    output logic                      done,
    output logic                      game_over
);

    localparam logic [1:0] c_ph_show   = 2'd0;
    localparam logic [1:0] c_ph_select = 2'd1;
    localparam logic [1:0] c_ph_check  = 2'd2;

    localparam logic [STEP_W-1:0] c_win  = STEP_W'(3 * ROUNDS);
    localparam logic [STEP_W-1:0] c_last = STEP_W'(3 * ROUNDS + END_STEPS);

    logic              r_btn_q;
    logic [STEP_W-1:0] r_step;
    logic [1:0]        r_phase;
    logic [2:0]        r_round;
    logic [MISS_W-1:0] r_miss;
    logic              r_match_p;
    logic              r_miss_p;
    logic              r_done;
    logic              r_lock;

    logic               w_press;
    logic [COLOR_W-1:0] w_sel;
    logic [COLOR_W-1:0] w_tgt;
    logic [COLOR_W-1:0] w_partner;
    logic               w_hit;
    logic [MISS_W-1:0]  w_miss_inc;
    logic               w_lock_now;
    logic [STEP_W-1:0]  w_step_inc;

    assign w_press    = button & ~r_btn_q;
    assign w_step_inc = r_step + STEP_W'(1);

    // Per-round operand select and partner table lookup, written as muxes
    // so no variable-offset part-select or divider is needed.
    always_comb begin
        w_sel = '0;
        w_tgt = '0;
        for (int i = 0; i < ROUNDS; i++) begin
            if (r_round == 3'(i)) begin
                w_sel = secim[COLOR_W*i +: COLOR_W];
                w_tgt = es[COLOR_W*i +: COLOR_W];
            end
        end
    end

    always_comb begin
        w_partner = '0;
        for (int c = 0; c < 2**COLOR_W; c++) begin
            if (w_sel == COLOR_W'(c)) begin
                w_partner = PARTNER[COLOR_W*c +: COLOR_W];
            end
        end
    end

    assign w_hit      = (w_partner == w_tgt);
    assign w_miss_inc = (r_miss == {MISS_W{1'b1}}) ? r_miss : r_miss + MISS_W'(1);
    assign w_lock_now = (MAX_MISS != 0) && (w_miss_inc == MISS_W'(MAX_MISS));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_btn_q   <= 1'b1;
            r_step    <= '0;
            r_phase   <= c_ph_show;
            r_round   <= 3'd0;
            r_miss    <= '0;
            r_match_p <= 1'b0;
            r_miss_p  <= 1'b0;
            r_done    <= 1'b0;
            r_lock    <= 1'b0;
        end else begin
            r_btn_q   <= button;
            r_match_p <= 1'b0;
            r_miss_p  <= 1'b0;
            if (w_press && !r_lock && !r_done) begin
                if (r_step >= c_win) begin
                    r_step <= w_step_inc;
                    if (w_step_inc == c_last) begin
                        r_done <= 1'b1;
                    end
                end else if (r_phase != c_ph_check) begin
                    r_step  <= w_step_inc;
                    r_phase <= (r_phase == c_ph_show) ? c_ph_select : c_ph_check;
                end else if (w_hit) begin
                    r_step    <= w_step_inc;
                    r_phase   <= c_ph_show;
                    r_round   <= r_round + 3'd1;
                    r_match_p <= 1'b1;
                    if (w_step_inc == c_last) begin
                        r_done <= 1'b1;
                    end
                end else begin
                    r_miss_p <= 1'b1;
                    r_miss   <= w_miss_inc;
                    r_lock   <= w_lock_now;
                    r_phase  <= c_ph_show;
                    // In the check phase the round base 3*r is simply step-2.
                    if (RETRY_MODE == 0) begin
                        r_step <= r_step - STEP_W'(2);
                    end else begin
                        r_step  <= '0;
                        r_round <= 3'd0;
                    end
                end
            end
        end
    end

    assign step        = r_step;
    assign round       = r_round;
    assign miss_cnt    = r_miss;
    assign match_pulse = r_match_p;
    assign miss_pulse  = r_miss_p;
    assign done        = r_done;
    assign game_over   = r_lock;

endmodule
`default_nettype wire

// File: doc/match_step_seq.md
Name: match_step_seq

Overview:
- Clocked, parametrised successor to the button-stepped colour-match sequencer. It sequences a game of ROUNDS rounds; each round has three button-advanced phases: show, select, check.
- At each check phase it compares the player's colour against the target colour using a programmable partner table.
- Adds features the earlier sequencer lacks: synchronous press edge detection, a miss counter, selectable retry mode, miss-limit lockout, and status pulses.
- Sits between the debounced button/switch logic and the display/LED drivers.

Parameters:
- ROUNDS, 3, number of match rounds (1..5).
- COLOR_W, 3, colour code width.
- PARTNER, 24'hA394E6, packed partner table; entry c is PARTNER[COLOR_W*c +: COLOR_W]. The default pairs 0-6, 1-4, 2-3, 5-7.
- END_STEPS, 3, number of post-win steps before the final hold.
- RETRY_MODE, 0, action on a miss: 0 = restart the current round, 1 = restart the whole game.
- MAX_MISS, 0, total misses that trigger lockout; 0 disables lockout.
- STEP_W, 4, step output width; must satisfy 2^STEP_W > 3*ROUNDS+END_STEPS.
- MISS_W, 4, miss counter width.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- button  input  1  debounced level, synchronous to clk
- secim  input  ROUNDS*COLOR_W  player colour per round; round r uses slice [COLOR_W*r +: COLOR_W]
- es  input  ROUNDS*COLOR_W  target colour per round, same packing as secim
- step  output  STEP_W  current step number
- round  output  3  current round index, 0..ROUNDS-1; reads ROUNDS once won
- miss_cnt  output  MISS_W  total misses since reset; saturates at all-ones
- match_pulse  output  1  one-cycle pulse on a successful check
- miss_pulse  output  1  one-cycle pulse on a failed check
- done  output  1  high while step == 3*ROUNDS+END_STEPS
- game_over  output  1  high while in lockout

Behaviour:
- Reset is synchronous and active-high: one clock, rst sampled on the rising edge of clk.
- Reset values: step=0, round=0, miss_cnt=0, all pulses 0, done=0, game_over=0, btn_q=1.
  - Because btn_q resets to 1, a button held through reset release produces no press.
- Press detection: press = button & ~btn_q, where btn_q is button registered on the previous edge. All state changes occur on the same clock edge at which press is detected. A held button gives exactly one press.
- Step encoding: step = 3*r + p, where r is the round and p is the phase (0 show, 1 select, 2 check).
- On a press with p = 0 or 1: step increments by 1.
- On a press with p = 2, evaluate round r:
  - hit = (partner(secim_r) == es_r).
  - hit: step <= 3*(r+1); match_pulse=1.
  - miss: miss_pulse=1; miss_cnt increments (saturating).
    - RETRY_MODE=0: step <= 3*r.
    - RETRY_MODE=1: step <= 0.
- Steps 3*ROUNDS .. 3*ROUNDS+END_STEPS-1 are win steps; each press advances step by 1.
- At step 3*ROUNDS+END_STEPS: done=1, step holds, presses are ignored.
- round output = step/3 while step < 3*ROUNDS; otherwise ROUNDS. Implemented as a registered counter updated alongside step; no divider.
- Lockout: with MAX_MISS != 0, a miss that brings the miss count to MAX_MISS sets game_over=1 on that edge.
  - miss_pulse still fires on that edge; step takes the normal retry target, then freezes.
  - All further presses are ignored until rst.
- Priority: rst > lockout/done hold > press.
- Pulses are high for exactly the cycle after the updating edge. They are never asserted without a press.
- secim/es are sampled only at the check-phase press edge; changes at other times have no effect.
- rst asserted mid-game on the same edge as a press: reset wins and the press is discarded.

Test Plan:
- Defaults; rst; 9 presses with round 0/1/2 pairs (0,6),(1,4),(5,7) -> match_pulse on presses 3, 6 and 9; step=9, round=3.
- Then 3 more presses -> step=12, done=1; a further press leaves step at 12 and produces no pulse.
- RETRY_MODE=0; round 1 pair (2,2); reach step 5 and press -> miss_pulse, step=3, miss_cnt=1, round=1.
- RETRY_MODE=1; same miss at step 5 -> step=0, round=0, miss_cnt=1.
- MAX_MISS=2; two round-0 misses -> second miss sets game_over=1, step=0; 5 further presses -> no change; rst -> all outputs 0.
- Hold button high for 20 cycles -> exactly one step increment; assert button during rst and keep it high after rst release -> step stays 0.
